scs8hd_demux2_reg: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It steers each accepted input word to one of two output branches, selected by `S`, and is the inverse of the 2:1 mux used on the converging side of a datapath. Each branch has a one-entry output register, so a stalled branch holds its word while the other branch keeps flowing. Per-branch beat counters support debug and bench scoreboarding.

---
 rtl/scs8hd_demux2_reg.sv | 84 ++++++++
 tb/tb_scs8hd_demux2_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_demux2_reg.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a one-entry output
// register and a wrapping beat counter on each branch.
module scs8hd_demux2_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic             S,
  output logic [WIDTH-1:0] X0,
  output logic             X0_VALID,
  input  logic             X0_READY,
  output logic [WIDTH-1:0] X1,
  output logic             X1_VALID,
  input  logic             X1_READY,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1
);

  logic [WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
  logic             x0_valid_q, x0_valid_d, x1_valid_q, x1_valid_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             free0, free1, accept, load0, load1;

  // A branch with a word being drained this cycle counts as free.
  assign free0   = !x0_valid_q || X0_READY;
  assign free1   = !x1_valid_q || X1_READY;
  assign A_READY = S ? free1 : free0;
  assign accept  = A_VALID && A_READY;
  assign load0   = accept && !S;
  assign load1   = accept && S;

  always_comb begin
    x0_d       = x0_q;
    x1_d       = x1_q;
    x0_valid_d = x0_valid_q;
    x1_valid_d = x1_valid_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    if (x0_valid_q && X0_READY) x0_valid_d = 1'b0;
    if (x1_valid_q && X1_READY) x1_valid_d = 1'b0;

    if (load0) begin
      x0_d       = A;
      x0_valid_d = 1'b1;
      cnt0_d     = cnt0_q + 1'b1;
    end
    if (load1) begin
      x1_d       = A;
      x1_valid_d = 1'b1;
      cnt1_d     = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x0_q       <= '0;
      x1_q       <= '0;
      x0_valid_q <= 1'b0;
      x1_valid_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      x0_valid_q <= x0_valid_d;
      x1_valid_q <= x1_valid_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign X0       = x0_q;
  assign X1       = x1_q;
  assign X0_VALID = x0_valid_q;
  assign X1_VALID = x1_valid_q;
  assign CNT0     = cnt0_q;
  assign CNT1     = cnt1_q;

endmodule

// File: tb/tb_scs8hd_demux2_reg.sv
// Scoreboard bench for scs8hd_demux2_reg: a default instance plus a CNT_W=4
// instance sharing the same stimulus for the counter-wrap case.
module tb_scs8hd_demux2_reg;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] A = '0;
  logic       A_VALID = 1'b0;
  logic       S = 1'b0;
  logic       X0_READY = 1'b1;
  logic       X1_READY = 1'b1;
  logic       A_READY, X0_VALID, X1_VALID;
  logic [7:0] X0, X1, CNT0, CNT1;
  logic       w_a_ready, w_x0_valid, w_x1_valid;
  logic [7:0] w_x0, w_x1;
  logic [3:0] w_cnt0, w_cnt1;

  int total  = 0;
  int passed = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  scs8hd_demux2_reg u_dut (
    .CLK(CLK), .RESET(RESET), .A(A), .A_VALID(A_VALID), .A_READY(A_READY), .S(S),
    .X0(X0), .X0_VALID(X0_VALID), .X0_READY(X0_READY),
    .X1(X1), .X1_VALID(X1_VALID), .X1_READY(X1_READY),
    .CNT0(CNT0), .CNT1(CNT1)
  );

  scs8hd_demux2_reg #(.WIDTH(8), .CNT_W(4)) u_w (
    .CLK(CLK), .RESET(RESET), .A(A), .A_VALID(A_VALID), .A_READY(w_a_ready), .S(S),
    .X0(w_x0), .X0_VALID(w_x0_valid), .X0_READY(X0_READY),
    .X1(w_x1), .X1_VALID(w_x1_valid), .X1_READY(X1_READY),
    .CNT0(w_cnt0), .CNT1(w_cnt1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a word leaves a branch at the next edge when VALID && READY.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (X0_VALID && X0_READY) begin
        if (q0.size() == 0) chk("x0_unexpected", X0, -1);
        else chk("x0_order", X0, q0.pop_front());
      end
      if (X1_VALID && X1_READY) begin
        if (q1.size() == 0) chk("x1_unexpected", X1, -1);
        else chk("x1_order", X1, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    A_VALID = 1'b0;
  endtask

  // Present a word and hold it until accepted; returns cycles spent waiting.
  task automatic send(input logic s, input logic [7:0] d, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    A = d;
    S = s;
    A_VALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (A_READY) ok = 1;
      else waited++;
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: word 0x%0h not accepted, required accept within 20 cycles", d);
    end else begin
      if (s) q1.push_back(d);
      else q0.push_back(d);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge CLK);
    RESET = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge CLK);
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    int w;
    // Reset state
    #12;
    chk("rst_x0", X0, 0);
    chk("rst_x0_valid", X0_VALID, 0);
    chk("rst_x1_valid", X1_VALID, 0);
    chk("rst_cnt0", CNT0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    S = 1'b0; #1 chk("rst_ready_s0", A_READY, 1);
    S = 1'b1; #1 chk("rst_ready_s1", A_READY, 1);
    tick();

    // Steering
    send(1'b0, 8'h11, w);
    chk("steer_x0", X0, 8'h11);
    chk("steer_x0_valid", X0_VALID, 1);
    send(1'b1, 8'h22, w);
    chk("steer_x1", X1, 8'h22);
    chk("steer_x1_valid", X1_VALID, 1);
    idle();
    chk("steer_cnt0", CNT0, 1);
    chk("steer_cnt1", CNT1, 1);
    tick();

    // Back-to-back streaming
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, 8'(i), w);
      chk("stream_ready", w, 0);
      chk("stream_x0", X0, i);
    end
    idle();
    chk("stream_cnt0", CNT0, 8);
    tick();

    // Stall isolation
    X0_READY = 1'b0;
    send(1'b0, 8'hAA, w);
    idle();
    S = 1'b0; A = 8'hCC; A_VALID = 1'b1;
    #1 chk("stall_ready_s0", A_READY, 0);
    tick(); tick();
    chk("stall_x0_hold", X0, 8'hAA);
    chk("stall_x0_valid", X0_VALID, 1);
    S = 1'b1; A = 8'hBB;
    #1 chk("stall_ready_s1", A_READY, 1);
    send(1'b1, 8'hBB, w);
    idle();
    chk("stall_x1", X1, 8'hBB);
    chk("stall_x0_unchanged", X0, 8'hAA);
    X0_READY = 1'b1;
    tick(); tick();

    // Simultaneous drain and load on branch 1
    send(1'b1, 8'h31, w);
    send(1'b1, 8'h32, w);
    idle();
    chk("dl_x1_valid", X1_VALID, 1);
    chk("dl_x1", X1, 8'h32);
    tick(); tick();

    // Asynchronous reset with a held word
    do_reset();
    for (int i = 0; i < 5; i++) send(1'b0, 8'h41 + 8'(i), w);
    idle();
    X0_READY = 1'b0;
    tick();
    chk("pre_rst_cnt0", CNT0, 5);
    chk("pre_rst_x0_valid", X0_VALID, 1);
    @(negedge CLK);
    #2 RESET = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("arst_x0", X0, 0);
    chk("arst_x0_valid", X0_VALID, 0);
    chk("arst_cnt0", CNT0, 0);
    chk("arst_w_cnt0", w_cnt0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    S = 1'b0; #1 chk("arst_ready", A_READY, 1);
    X0_READY = 1'b1;
    tick();

    // Counter wrap (CNT_W=4 instance)
    do_reset();
    for (int i = 0; i < 17; i++) send(1'b1, 8'h60 + 8'(i), w);
    idle();
    chk("wrap_w_cnt1", w_cnt1, 1);
    chk("wrap_w_cnt0", w_cnt0, 0);
    chk("wrap_cnt1_8bit", CNT1, 17);
    tick(); tick();

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
